// File: rtl/operand_mux_reg_if.sv
// Handshake bundle for operand_mux_reg: N input channels, selection control,
// one registered output channel and the beat counter.
interface operand_mux_reg_if #(
    parameter int WIDTH  = 6,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = 1,
    parameter int CNT_W  = 8
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic                    sel_load;
    logic [SEL_W-1:0]        cur_sel;
    logic                    sel_err;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        xfer_cnt;

    modport master (
        output in_data, in_valid, sel, sel_load, out_ready,
        input  in_ready, cur_sel, sel_err, out_data, out_valid, xfer_cnt
    );

    modport slave (
        input  in_data, in_valid, sel, sel_load, out_ready,
        output in_ready, cur_sel, sel_err, out_data, out_valid, xfer_cnt
    );
endinterface

// File: rtl/operand_mux_reg.sv
// Registered N-way operand selector: forwards one beat per cycle from the
// programmed channel through a single output register and counts accepted beats.
module operand_mux_reg #(
    parameter int WIDTH  = 6,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = 1,
    parameter int CNT_W  = 8
) (
    input logic             clk,
    input logic             rst,
    operand_mux_reg_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             can_take;
    logic             accept;
    logic             sel_ok;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;

    logic [SEL_W-1:0] cur_sel;
    logic             sel_err;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CNT_W-1:0] xfer_cnt;

    assign can_take = !out_valid || bus.out_ready;
    assign accept   = sel_valid && can_take;
    assign sel_ok   = (32'(bus.sel) < 32'(NUM_IN));

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        sel_data     = '0;
        sel_valid    = 1'b0;
        bus.in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                sel_data        = bus.in_data[i*WIDTH +: WIDTH];
                sel_valid       = bus.in_valid[i];
                bus.in_ready[i] = can_take;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel   <= '0;
            sel_err   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            if (accept) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end

            sel_err <= bus.sel_load && !sel_ok;

            // A valid reload wins over the count: the beat accepted on the same edge is not counted.
            if (bus.sel_load && sel_ok) begin
                cur_sel  <= bus.sel;
                xfer_cnt <= '0;
            end else if (accept && xfer_cnt != CNT_MAX) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cur_sel   = cur_sel;
    assign bus.sel_err   = sel_err;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.xfer_cnt  = xfer_cnt;

endmodule

// File: tb/tb_operand_mux_reg.sv
// Randomised and directed bench for operand_mux_reg (4 channels, 8-bit data,
// 2-bit saturating counter) checked against a transaction-level model.
module tb_operand_mux_reg;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    operand_mux_reg_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    operand_mux_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: what the output register, selection and counter should hold.
    int m_sel;
    bit m_valid;
    int m_data;
    int m_cnt;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel   = 0;
        m_valid = 1'b0;
        m_data  = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(bus.out_data),  m_data);
        check({tag, ".cur_sel"},   32'(bus.cur_sel),   m_sel);
        check({tag, ".xfer_cnt"},  32'(bus.xfer_cnt),  m_cnt);
        check({tag, ".sel_err"},   32'(bus.sel_err),   32'(m_err));
    endtask

    // One clock: apply inputs, check the combinational ready, advance the model,
    // take the edge and compare every registered output.
    task automatic cycle(input string tag, input logic [3:0] v, input logic [31:0] d,
                         input logic ordy, input logic ld, input logic [2:0] s);
        bit take;
        bit acc;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.sel_load  = ld;
        bus.sel       = s;
        #1;
        take = !m_valid || ordy;
        check({tag, ".in_ready"}, 32'(bus.in_ready), take ? (32'd1 << m_sel) : 32'd0);

        acc = take && v[m_sel];
        if (acc) begin
            m_data  = int'((d >> (8 * m_sel)) & 32'hFF);
            m_valid = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        m_err = ld && (int'(s) >= NUM_IN);
        if (ld && int'(s) < NUM_IN) begin
            m_sel = int'(s);
            m_cnt = 0;
        end else if (acc) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end

        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.sel_load  = 1'b0;
        bus.sel       = '0;
        model_reset();

        #3;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Channel 0 beat straight after reset.
        cycle("ch0", 4'b0001, 32'h0000_0011, 1'b1, 1'b0, 3'd0);
        check("ch0.data_const", 32'(bus.out_data), 32'h11);
        check("ch0.cnt_const",  32'(bus.xfer_cnt), 32'd1);

        // Switch to channel 2 and stream three beats; channel 0 stays valid but must not be taken.
        cycle("load2", 4'b0001, 32'h0000_0022, 1'b1, 1'b1, 3'd2);
        cycle("s0", 4'b0101, 32'h00A0_0033, 1'b1, 1'b0, 3'd0);
        cycle("s1", 4'b0101, 32'h00A1_0034, 1'b1, 1'b0, 3'd0);
        cycle("s2", 4'b0101, 32'h00A2_0035, 1'b1, 1'b0, 3'd0);
        check("stream.data_const", 32'(bus.out_data), 32'hA2);
        check("stream.cnt_const",  32'(bus.xfer_cnt), 32'd3);

        // Back-pressure for three cycles, then release.
        for (int i = 0; i < 3; i++) cycle("stall", 4'b0100, 32'h00A3_0000, 1'b0, 1'b0, 3'd0);
        check("stall.data_const", 32'(bus.out_data), 32'hA2);
        cycle("rel0", 4'b0100, 32'h00A3_0000, 1'b1, 1'b0, 3'd0);
        cycle("rel1", 4'b0100, 32'h00A4_0000, 1'b1, 1'b0, 3'd0);
        check("rel.data_const", 32'(bus.out_data), 32'hA4);

        // Out-of-range selection: one-cycle error pulse, nothing else moves.
        cycle("bad_sel", 4'b0000, 32'h0, 1'b1, 1'b1, 3'd5);
        check("bad_sel.err_const", 32'(bus.sel_err), 32'd1);
        cycle("bad_sel_after", 4'b0000, 32'h0, 1'b1, 1'b0, 3'd0);
        check("bad_sel.err_clear", 32'(bus.sel_err), 32'd0);

        // Reload to channel 1 on the same edge as a channel 2 accept.
        cycle("swap", 4'b0110, 32'h00B0_C000, 1'b1, 1'b1, 3'd1);
        check("swap.data_const", 32'(bus.out_data), 32'hB0);
        check("swap.cnt_const",  32'(bus.xfer_cnt), 32'd0);
        cycle("swap_next", 4'b0110, 32'h00B1_C100, 1'b1, 1'b0, 3'd0);
        check("swap_next.data_const", 32'(bus.out_data), 32'hC1);

        // Counter saturation.
        for (int i = 0; i < 5; i++) cycle("sat", 4'b0010, 32'(i) << 8, 1'b1, 1'b0, 3'd0);
        check("sat.cnt_const", 32'(bus.xfer_cnt), 32'd3);

        // Asynchronous reset in the middle of a stream.
        cycle("pre_rst", 4'b0010, 32'h0000_5500, 1'b0, 1'b0, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        #2;
        rst = 1'b0;
        cycle("post_rst", 4'b0011, 32'h0000_6677, 1'b1, 1'b0, 3'd0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 4'($urandom), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
